seg7_scan_driver: RTL

- Output-side counterpart to the board's button/switch input conditioning: drives the Nexys4 8-digit multiplexed seven-segment display from a 32-bit hex value.
- Scans one digit per slot, decodes hex nibbles, and applies per-digit blanking and decimal points.
- Inserts anode dead time between slots to suppress ghosting.
- Double-buffers the displayed value so a frame never shows mixed old/new data.

---
 rtl/seg7_scan_driver.sv | 92 +++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit multiplexed hex display scanner with anode dead time,
// per-digit blank/dp and a frame-aligned double buffer.
module seg7_scan_driver #(
    parameter int SCAN_DIV    = 100000,
    parameter int DEAD_CYCLES = 1000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank_in,
    output logic        load_pending,
    output logic        frame_done,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [111:0] HEX = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [7:0]    act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic [7:0]    act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic          load_pending_q, load_pending_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          wrap, last, swap, dark;
    logic [3:0]    nib;
    always_comb begin
        wrap           = cnt_q == CW'(SCAN_DIV - 1);
        last           = idx_q == 3'(NUM_DIGITS - 1);
        swap           = wrap && last && load_pending_q;
        cnt_d          = wrap ? '0 : cnt_q + 1'b1;
        idx_d          = wrap ? (last ? 3'd0 : idx_q + 3'd1) : idx_q;
        act_data_d     = swap ? pend_data_q : act_data_q;
        act_dp_d       = swap ? pend_dp_q : act_dp_q;
        act_blank_d    = swap ? pend_blank_q : act_blank_q;
        pend_data_d    = load ? data_in : pend_data_q;
        pend_dp_d      = load ? dp_in : pend_dp_q;
        pend_blank_d   = load ? blank_in : pend_blank_q;
        // a load on the swap edge refills pending, so the flag must survive
        load_pending_d = load | (load_pending_q & ~swap);
        nib            = act_data_q[{idx_q, 2'b00} +: 4];
        dark           = act_blank_q[idx_q];
        an_d           = (cnt_q < CW'(DEAD_CYCLES)) ? 8'hFF : ~(8'b1 << idx_q);
        seg_d          = dark ? 7'h7F : HEX[7'(nib) * 7'd7 +: 7];
        dp_d           = ~(act_dp_q[idx_q] & ~dark);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            act_data_q     <= '0;
            act_dp_q       <= '0;
            act_blank_q    <= '0;
            pend_data_q    <= '0;
            pend_dp_q      <= '0;
            pend_blank_q   <= '0;
            load_pending_q <= 1'b0;
            an_q           <= 8'hFF;
            seg_q          <= 7'h7F;
            dp_q           <= 1'b1;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            act_data_q     <= act_data_d;
            act_dp_q       <= act_dp_d;
            act_blank_q    <= act_blank_d;
            pend_data_q    <= pend_data_d;
            pend_dp_q      <= pend_dp_d;
            pend_blank_q   <= pend_blank_d;
            load_pending_q <= load_pending_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
        end
    end
    assign frame_done   = wrap && last;
    assign load_pending = load_pending_q;
    assign AN           = an_q;
    assign SEG          = seg_q;
    assign DP           = dp_q;
endmodule
